// File: rtl/id_ex_stage_pkg.sv
// Shared widths, forward-select encoding and the ID/EX register record.
package id_ex_stage_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    // Operand source chosen by a forwarding unit
    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_ZERO  = 2'b11
    } fwd_sel_e;

    // Everything the ID/EX register holds for one instruction
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1_addr;
        logic [REG_ADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  branch;
    } ex_fields_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, writeback forwarding ports and EX-side outputs of the ID/EX stage.
// The forward-select signals expose which source each operand is using.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic                  id_valid;
    logic [XLEN-1:0]       id_pc;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic [2:0]            id_funct3;
    logic [6:0]            id_funct7;
    logic                  id_alu_src;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_mem_to_reg;
    logic                  id_branch;
    logic                  stall_in;
    logic                  flush;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [XLEN-1:0]       exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [XLEN-1:0]       memwb_result;

    logic                  id_stall;
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_pc;
    logic [XLEN-1:0]       ex_imm;
    logic [XLEN-1:0]       ex_a;
    logic [XLEN-1:0]       ex_b;
    logic [XLEN-1:0]       ex_store_data;
    logic [2:0]            ex_funct3;
    logic [6:0]            ex_funct7;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  ex_branch;
    fwd_sel_e              ex_rs1_fwd_sel;
    fwd_sel_e              ex_rs2_fwd_sel;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_rd_addr, id_funct3, id_funct7, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch, stall_in, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  id_stall, ex_valid, ex_pc, ex_imm, ex_a, ex_b, ex_store_data,
               ex_funct3, ex_funct7, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_rs1_fwd_sel, ex_rs2_fwd_sel
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_rd_addr, id_funct3, id_funct7, id_alu_src, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, id_branch, stall_in, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output id_stall, ex_valid, ex_pc, ex_imm, ex_a, ex_b, ex_store_data,
               ex_funct3, ex_funct7, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_branch, ex_rs1_fwd_sel, ex_rs2_fwd_sel
    );

endinterface

// File: rtl/id_ex_stage_forwarding_unit.sv
// Per-operand forwarding: picks x0, EX/MEM, MEM/WB or regfile data for one source index.
module forwarding_unit
    import id_ex_stage_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]       reg_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output fwd_sel_e              sel,
    output logic [XLEN-1:0]       value
);

    // Source priority: x0, then the younger EX/MEM result, then MEM/WB, then regfile
    always_comb begin
        sel = FWD_REG;
        if (addr == '0)
            sel = FWD_ZERO;
        else if (exmem_reg_write && (exmem_rd == addr) && (exmem_rd != '0))
            sel = FWD_EXMEM;
        else if (memwb_reg_write && (memwb_rd == addr) && (memwb_rd != '0))
            sel = FWD_MEMWB;
    end

    // Operand value for the chosen source
    always_comb begin
        value = reg_data;
        case (sel)
            FWD_ZERO:  value = '0;
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_result;
            default:   value = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and zero-cycle operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    ex_fields_t            ex_reg;
    ex_fields_t            ex_next;
    ex_fields_t            id_fields;
    logic                  load_use;

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]       src_data [2];
    fwd_sel_e              src_sel  [2];
    logic [XLEN-1:0]       src_fwd  [2];

    // Load in EX whose destination is read by the instruction in ID
    assign load_use = bus.id_valid && ex_reg.valid && ex_reg.mem_read && (ex_reg.rd != '0) &&
                      ((ex_reg.rd == bus.id_rs1_addr) || (ex_reg.rd == bus.id_rs2_addr));

    assign bus.id_stall = load_use || bus.stall_in;

    assign id_fields = '{
        valid:      bus.id_valid,
        pc:         bus.id_pc,
        imm:        bus.id_imm,
        rs1_addr:   bus.id_rs1_addr,
        rs2_addr:   bus.id_rs2_addr,
        rs1_data:   bus.id_rs1_data,
        rs2_data:   bus.id_rs2_data,
        rd:         bus.id_rd_addr,
        funct3:     bus.id_funct3,
        funct7:     bus.id_funct7,
        alu_src:    bus.id_alu_src,
        reg_write:  bus.id_reg_write,
        mem_read:   bus.id_mem_read,
        mem_write:  bus.id_mem_write,
        mem_to_reg: bus.id_mem_to_reg,
        branch:     bus.id_branch
    };

    // Next register contents: flush beats stall, stall holds, load-use inserts a bubble
    always_comb begin
        ex_next = ex_reg;
        if (bus.flush)
            ex_next = '0;
        else if (bus.stall_in)
            ex_next = ex_reg;
        else if (load_use)
            ex_next = '0;
        else
            ex_next = id_fields;
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst)
            ex_reg <= '0;
        else
            ex_reg <= ex_next;
    end

    assign src_addr[0] = ex_reg.rs1_addr;
    assign src_addr[1] = ex_reg.rs2_addr;
    assign src_data[0] = ex_reg.rs1_data;
    assign src_data[1] = ex_reg.rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            forwarding_unit u_fwd (
                .addr            (src_addr[gi]),
                .reg_data        (src_data[gi]),
                .exmem_reg_write (bus.exmem_reg_write),
                .exmem_rd        (bus.exmem_rd),
                .exmem_result    (bus.exmem_result),
                .memwb_reg_write (bus.memwb_reg_write),
                .memwb_rd        (bus.memwb_rd),
                .memwb_result    (bus.memwb_result),
                .sel             (src_sel[gi]),
                .value           (src_fwd[gi])
            );
        end
    endgenerate

    assign bus.ex_valid       = ex_reg.valid;
    assign bus.ex_pc          = ex_reg.pc;
    assign bus.ex_imm         = ex_reg.imm;
    assign bus.ex_a           = src_fwd[0];
    assign bus.ex_b           = ex_reg.alu_src ? ex_reg.imm : src_fwd[1];
    assign bus.ex_store_data  = src_fwd[1];
    assign bus.ex_funct3      = ex_reg.funct3;
    assign bus.ex_funct7      = ex_reg.funct7;
    assign bus.ex_rd          = ex_reg.rd;
    assign bus.ex_reg_write   = ex_reg.reg_write;
    assign bus.ex_mem_read    = ex_reg.mem_read;
    assign bus.ex_mem_write   = ex_reg.mem_write;
    assign bus.ex_mem_to_reg  = ex_reg.mem_to_reg;
    assign bus.ex_branch      = ex_reg.branch;
    assign bus.ex_rs1_fwd_sel = src_sel[0];
    assign bus.ex_rs2_fwd_sel = src_sel[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    // The model remembers the instruction currently in EX as a plain record.
    ex_fields_t m;
    bit         m_live = 0;

    function automatic bit model_load_use();
        return bus.id_valid && m.valid && m.mem_read && (m.rd != 0) &&
               ((m.rd == bus.id_rs1_addr) || (m.rd == bus.id_rs2_addr));
    endfunction

    function automatic logic [63:0] model_fwd(input logic [4:0] a, input logic [63:0] d);
        if (a == 0) return 64'd0;
        if (bus.exmem_reg_write && bus.exmem_rd == a) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == a) return bus.memwb_result;
        return d;
    endfunction

    function automatic logic [1:0] model_sel(input logic [4:0] a);
        if (a == 0) return 2'd3;
        if (bus.exmem_reg_write && bus.exmem_rd == a) return 2'd2;
        if (bus.memwb_reg_write && bus.memwb_rd == a) return 2'd1;
        return 2'd0;
    endfunction

    always @(posedge clk) begin
        bit lu;
        lu = model_load_use();
        if (rst || bus.flush || (!bus.stall_in && lu)) begin
            m = '0;
        end else if (!bus.stall_in) begin
            m.valid = bus.id_valid;       m.pc = bus.id_pc;          m.imm = bus.id_imm;
            m.rs1_addr = bus.id_rs1_addr; m.rs2_addr = bus.id_rs2_addr;
            m.rs1_data = bus.id_rs1_data; m.rs2_data = bus.id_rs2_data;
            m.rd = bus.id_rd_addr;        m.funct3 = bus.id_funct3;  m.funct7 = bus.id_funct7;
            m.alu_src = bus.id_alu_src;   m.reg_write = bus.id_reg_write;
            m.mem_read = bus.id_mem_read; m.mem_write = bus.id_mem_write;
            m.mem_to_reg = bus.id_mem_to_reg; m.branch = bus.id_branch;
        end
        if (rst) m_live = 1;
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_live) begin
            logic [63:0] fa, fb;
            fa = model_fwd(m.rs1_addr, m.rs1_data);
            fb = model_fwd(m.rs2_addr, m.rs2_data);
            cmp("id_stall",   bus.id_stall,      64'(model_load_use() || bus.stall_in));
            cmp("ex_valid",   bus.ex_valid,      64'(m.valid));
            cmp("ex_pc",      bus.ex_pc,         m.pc);
            cmp("ex_imm",     bus.ex_imm,        m.imm);
            cmp("ex_a",       bus.ex_a,          fa);
            cmp("ex_b",       bus.ex_b,          m.alu_src ? m.imm : fb);
            cmp("ex_store",   bus.ex_store_data, fb);
            cmp("ex_funct3",  bus.ex_funct3,     64'(m.funct3));
            cmp("ex_funct7",  bus.ex_funct7,     64'(m.funct7));
            cmp("ex_rd",      bus.ex_rd,         64'(m.rd));
            cmp("ex_ctrl",    {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                               bus.ex_mem_to_reg, bus.ex_branch},
                              {m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg, m.branch});
            cmp("rs1_sel",    bus.ex_rs1_fwd_sel, 64'(model_sel(m.rs1_addr)));
            cmp("rs2_sel",    bus.ex_rs2_fwd_sel, 64'(model_sel(m.rs2_addr)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_rd_addr = '0;
        bus.id_funct3 = '0; bus.id_funct7 = '0; bus.id_alu_src = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.id_branch = 0;
    endtask

    task automatic idle_wb();
        bus.exmem_reg_write = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
        bus.memwb_reg_write = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
    endtask

    logic [63:0] snap_pc, snap_a, snap_b;

    initial begin
        rst = 1; bus.flush = 0; bus.stall_in = 0;
        clear_id(); idle_wb();

        // Reset for two cycles
        step(); step();
        rst = 0;
        cmp("rst_ex_valid", bus.ex_valid, 0);
        cmp("rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                         bus.ex_mem_to_reg, bus.ex_branch}, 0);
        cmp("rst_ex_a", bus.ex_a, 0);
        $display("txn reset done");

        // addi x5, x1, 12 with x1 = 100
        bus.id_valid = 1; bus.id_pc = 64'h1000; bus.id_rs1_addr = 1; bus.id_rs1_data = 100;
        bus.id_imm = 12; bus.id_alu_src = 1; bus.id_rd_addr = 5; bus.id_reg_write = 1;
        step();
        clear_id();
        cmp("addi_ex_a", bus.ex_a, 100);
        cmp("addi_ex_b", bus.ex_b, 12);
        cmp("addi_funct3", bus.ex_funct3, 0);
        $display("txn addi a=%0d b=%0d", bus.ex_a, bus.ex_b);

        // Double hazard on x3: EX/MEM beats MEM/WB
        bus.id_valid = 1; bus.id_rs1_addr = 3; bus.id_rs1_data = 55; bus.id_rd_addr = 8;
        bus.id_reg_write = 1;
        step();
        clear_id();
        bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 7;
        bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 9;
        #1 cmp("fwd_exmem_wins", bus.ex_a, 7);
        bus.exmem_reg_write = 0;
        #1 cmp("fwd_memwb", bus.ex_a, 9);
        $display("txn forward x3 a=%0d", bus.ex_a);
        idle_wb();
        step();

        // x0 source never forwards
        bus.id_valid = 1; bus.id_rs1_addr = 0; bus.id_rs1_data = 123;
        step();
        clear_id();
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 64'hFF;
        #1 cmp("x0_zero", bus.ex_a, 0);
        $display("txn x0 a=%0d", bus.ex_a);
        idle_wb();

        // Load-use: ld x4 then sd reading x4
        bus.id_valid = 1; bus.id_rs1_addr = 2; bus.id_rd_addr = 4; bus.id_mem_read = 1;
        bus.id_reg_write = 1; bus.id_mem_to_reg = 1; bus.id_alu_src = 1; bus.id_funct3 = 3'b011;
        step();
        clear_id();
        bus.id_valid = 1; bus.id_rs1_addr = 2; bus.id_rs2_addr = 4; bus.id_rs2_data = 64'h55;
        bus.id_mem_write = 1; bus.id_alu_src = 1; bus.id_imm = 16; bus.id_funct3 = 3'b011;
        #1 cmp("lu_stall", bus.id_stall, 1);
        step();
        cmp("lu_bubble_valid", bus.ex_valid, 0);
        cmp("lu_bubble_rw", bus.ex_reg_write, 0);
        cmp("lu_release", bus.id_stall, 0);
        step();
        clear_id();
        bus.memwb_reg_write = 1; bus.memwb_rd = 4; bus.memwb_result = 64'h1234_5678;
        #1 cmp("lu_store_data", bus.ex_store_data, 64'h1234_5678);
        cmp("lu_sd_valid", bus.ex_valid, 1);
        $display("txn load-use store_data=%h", bus.ex_store_data);
        idle_wb();

        // Flush beats stall_in
        bus.id_valid = 1; bus.id_pc = 64'h2000; bus.id_reg_write = 1; bus.id_rd_addr = 9;
        step();
        bus.id_pc = 64'h2004; bus.flush = 1; bus.stall_in = 1;
        #1 cmp("flush_stall_req", bus.id_stall, 1);
        step();
        bus.flush = 0; bus.stall_in = 0;
        cmp("flush_valid", bus.ex_valid, 0);
        cmp("flush_pc", bus.ex_pc, 0);
        $display("txn flush valid=%0d", bus.ex_valid);

        // stall_in alone holds everything for three cycles
        bus.id_valid = 1; bus.id_pc = 64'h3000; bus.id_rs1_addr = 7; bus.id_rs1_data = 77;
        bus.id_rs2_addr = 8; bus.id_rs2_data = 88; bus.id_rd_addr = 10; bus.id_reg_write = 1;
        step();
        snap_pc = bus.ex_pc; snap_a = bus.ex_a; snap_b = bus.ex_b;
        bus.stall_in = 1;
        for (int k = 0; k < 3; k++) begin
            bus.id_pc = {$urandom, $urandom}; bus.id_rs1_data = {$urandom, $urandom};
            bus.id_rs2_data = {$urandom, $urandom};
            step();
            cmp("hold_pc", bus.ex_pc, 64'h3000);
            cmp("hold_a", bus.ex_a, 77);
            cmp("hold_b", bus.ex_b, snap_b);
            cmp("hold_stall", bus.id_stall, 1);
            $display("txn hold %0d pc=%h a=%0d", k, bus.ex_pc, bus.ex_a);
        end
        bus.stall_in = 0;
        clear_id();
        step();

        // Store with negative immediate, rs2 forwarded from EX/MEM
        bus.id_valid = 1; bus.id_rs1_addr = 1; bus.id_rs2_addr = 6; bus.id_rs2_data = 64'h1111;
        bus.id_imm = 64'hFFFF_FFFF_FFFF_FFF8; bus.id_alu_src = 1; bus.id_mem_write = 1;
        bus.id_funct3 = 3'b011;
        step();
        clear_id();
        bus.exmem_reg_write = 1; bus.exmem_rd = 6; bus.exmem_result = 64'hDEAD;
        #1 cmp("st_ex_b", bus.ex_b, 64'hFFFF_FFFF_FFFF_FFF8);
        cmp("st_store_data", bus.ex_store_data, 64'hDEAD);
        $display("txn store b=%h sd=%h", bus.ex_b, bus.ex_store_data);
        idle_wb();
        step();

        // Randomized traffic; the per-cycle comparison does the checking
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.stall_in = ($urandom_range(0, 9) == 0);
            bus.id_valid = ($urandom_range(0, 9) < 8);
            bus.id_pc = {$urandom, $urandom};
            bus.id_rs1_addr = 5'($urandom_range(0, 7));
            bus.id_rs2_addr = 5'($urandom_range(0, 7));
            bus.id_rs1_data = {$urandom, $urandom};
            bus.id_rs2_data = {$urandom, $urandom};
            bus.id_imm = {$urandom, $urandom};
            bus.id_rd_addr = 5'($urandom_range(0, 7));
            bus.id_funct3 = 3'($urandom);
            bus.id_funct7 = 7'($urandom);
            bus.id_alu_src = 1'($urandom);
            bus.id_reg_write = 1'($urandom);
            bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = 1'($urandom);
            bus.id_mem_to_reg = 1'($urandom);
            bus.id_branch = 1'($urandom);
            bus.exmem_reg_write = 1'($urandom);
            bus.exmem_rd = 5'($urandom_range(0, 7));
            bus.exmem_result = {$urandom, $urandom};
            bus.memwb_reg_write = 1'($urandom);
            bus.memwb_rd = 5'($urandom_range(0, 7));
            bus.memwb_result = {$urandom, $urandom};
            step();
            if (c % 500 == 0)
                $display("txn random %0d valid=%0d stall=%0d", c, bus.ex_valid, bus.id_stall);
        end
        rst = 0; bus.flush = 0; bus.stall_in = 0;
        clear_id(); idle_wb();
        step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic for the pipelined RV64 core.
- Captures decoded fields from ID and presents forwarded, muxed operands (a, b, funct3, funct7) directly to the 64-bit ALU in EX.
- Generates the stall request that freezes IF/ID on a load-use hazard, and inserts bubbles on flush.

Parameters:
XLEN, 64, datapath width
REG_ADDR_W, 5, register-index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_addr  in  REG_ADDR_W  source 1 index
id_rs2_addr  in  REG_ADDR_W  source 2 index
id_rs1_data  in  XLEN  regfile read 1
id_rs2_data  in  XLEN  regfile read 2
id_imm  in  XLEN  sign-extended immediate
id_rd_addr  in  REG_ADDR_W  destination index
id_funct3  in  3  ALU funct3
id_funct7  in  7  ALU funct7
id_alu_src  in  1  1 = operand b is immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bits
stall_in  in  1  downstream stall, hold ID/EX
flush  in  1  branch redirect, kill ID/EX contents
exmem_reg_write  in  1  EX/MEM writes rd
exmem_rd  in  REG_ADDR_W  EX/MEM destination
exmem_result  in  XLEN  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes rd
memwb_rd  in  REG_ADDR_W  MEM/WB destination
memwb_result  in  XLEN  MEM/WB writeback value
id_stall  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  EX instruction valid
ex_pc, ex_imm  out  XLEN  registered copies
ex_a  out  XLEN  ALU operand a (forwarded rs1)
ex_b  out  XLEN  ALU operand b
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_funct3  out  3  to ALU
ex_funct7  out  7  to ALU
ex_rd  out  REG_ADDR_W  destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset: every registered field, including ex_valid and all control bits, is 0. ex_a, ex_b and ex_store_data therefore read 0 unless a forward matches.
- Register update priority per edge: rst > flush > stall_in (hold all fields) > load_use (bubble) > load from ID.
- Bubble / flush: ex_valid and all five control bits are 0. Data fields are zeroed.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1_addr | ex_rd==id_rs2_addr). This is combinational on current state.
- id_stall = load_use | stall_in. Under flush, load_use still drives id_stall, but the register takes the flush.
- Forwarding applies to registered rs1/rs2, per operand, all combinational:
  - Register index 0 gives 0.
  - Otherwise, exmem_reg_write & exmem_rd==addr & exmem_rd!=0 selects exmem_result.
  - Otherwise, memwb_reg_write & memwb_rd==addr & memwb_rd!=0 selects memwb_result.
  - Otherwise, the registered regfile data is used.
  - EX/MEM always wins over MEM/WB.
- ex_a = fwd_rs1. ex_b = alu_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 regardless of alu_src.
- Latency: one cycle from ID inputs to ex_* outputs. The forwarding path is zero-cycle.
- Stall: rs addresses, data and control are held unchanged. Forwarding keeps re-evaluating, so held operands pick up newly arrived results.
- The block does not check ex_valid on forwarding sources; upstream stages clear reg_write on bubbles.

Decomposition:
- Shared package holds XLEN, REG_ADDR_W, and the forward-select encoding: FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10, FWD_ZERO=2'b11.
- One sub-module, forwarding_unit. It is instantiated twice (rs1, rs2) and takes address plus both writeback ports. It returns the select and the value.

Test Plan:
- Reset and capture: rst for 2 cycles -> ex_valid=0, all control 0, ex_a=0. Next, load addi x5,x1,12 with x1 data=100 -> one cycle later ex_a=100, ex_b=12, ex_funct3=000.
- EX/MEM and MEM/WB both write x3 (exmem_result=7, memwb_result=9); EX has rs1=x3 -> ex_a=7. Drop exmem_reg_write -> ex_a=9.
- x0 source with exmem_rd=0, exmem_reg_write=1, result=0xFF -> ex_a=0.
- Load-use: ld x4 in EX (mem_read=1), ID rs2=x4, id_valid=1 -> id_stall=1. Next cycle ex_valid=0, ex_reg_write=0. The following cycle the ID instruction enters and ex_store_data equals memwb_result.
- Flush and stall_in both high with valid ID -> next cycle ex_valid=0 (flush wins). stall_in alone -> all ex_* fields are unchanged across 3 cycles and id_stall=1.
- Store with alu_src=1, imm=-8, rs2=x6 forwarded from EX/MEM value 0xDEAD -> ex_b=0xFFFF_FFFF_FFFF_FFF8, ex_store_data=0xDEAD.
